mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar word width.
REQ-002 SHALL have parameter VLEN, default 128, vector register width (4 x XLEN).
REQ-003 SHALL have parameter RA_W, default 5, register address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  load/store unit busy; high = MEM instruction not complete.
REQ-007 flush  input  1  kill the instruction currently leaving MEM.
REQ-008 in_valid  input  1  MEM stage holds a real instruction.
REQ-009 in_vector  input  1  instruction is a vector op.
REQ-010 in_mem_to_reg  input  1  result source is memory (load), else ALU.
REQ-011 in_reg_write  input  1  instruction writes a register.
REQ-012 in_rd  input  RA_W  destination register.
REQ-013 in_alu_result  input  VLEN  ALU result (scalar in bits [XLEN-1:0]).
REQ-014 mem_readdata  input  VLEN  load data from load/store unit, valid during the WB cycle.
REQ-015 wb_valid  output  1  WB stage holds a real instruction.
REQ-016 wb_scalar_we / wb_vector_we  output  1 each  register-file write enables.
REQ-017 wb_rd  output  RA_W  write address.
REQ-018 wb_data  output  VLEN  write data; also the forwarding value to EX.
REQ-019 retired_cnt / stall_cnt  output  32 each  performance counters.

Function
REQ-020 SHALL register valid, vector, mem_to_reg, reg_write, rd, alu_result on each rising edge; WB outputs appear exactly one cycle after capture.
REQ-021 Edge priority SHALL be reset > flush > stall > capture.
REQ-022 flush high: valid_q <= 0; other fields don't-care.
REQ-023 stall high (no flush): valid_q <= 0 (bubble); data fields hold.
REQ-024 stall low, flush low: valid_q <= in_valid, all fields captured.
REQ-025 Load data is NOT registered: when mem_to_reg_q, wb_data SHALL be taken combinationally from mem_readdata in the WB cycle.
REQ-026 wb_data: load+vector = mem_readdata; load+scalar = {zeros, mem_readdata[XLEN-1:0]}; ALU+vector = alu_result_q; ALU+scalar = {zeros, alu_result_q[XLEN-1:0]}.
REQ-027 wb_scalar_we = valid_q & reg_write_q & ~vector_q & (rd_q != 0); scalar register 0 is never written.
REQ-028 wb_vector_we = valid_q & reg_write_q & vector_q; vector register 0 is writable.
REQ-029 wb_rd = rd_q regardless of valid; consumers SHALL qualify with the write enables.
REQ-030 Stall held N cycles SHALL yield N bubbles then exactly one capture on the first low cycle.

Reset
REQ-031 On reset: valid_q, vector_q, mem_to_reg_q, reg_write_q = 0; rd_q = 0; alu_result_q = 0; counters = 0; therefore wb_valid, both write enables and wb_data (ALU path) = 0.
REQ-032 Reset asserted mid-stall SHALL drop any pending instruction; first capture follows first edge with reset low and stall low.

Configuration
REQ-033 Macro MEM_WB_PERF_CNT_EN defined: retired_cnt +1 on each edge where wb_valid was high; stall_cnt +1 on each edge where stall=1 and flush=0; both wrap 0xFFFFFFFF -> 0.
REQ-034 Macro undefined: counter ports SHALL remain present, tied to 0; no counter flops.

Structure
REQ-035 Package cpu_pkg SHALL hold XLEN, VLEN, RA_W and enum wb_src_t {WB_ALU, WB_MEM}.
REQ-036 Counters SHALL be instances of sub-module event_counter (32-bit, enable, async reset), generated only under MEM_WB_PERF_CNT_EN.

Verification
REQ-037 Scalar ALU: in_valid=1, reg_write=1, rd=5, alu_result=0x...DEADBEEF -> next cycle wb_scalar_we=1, wb_rd=5, wb_data=0x000..0DEADBEEF.
REQ-038 Vector load: capture vector load rd=3, drive mem_readdata=0x44444444_33333333_22222222_11111111 in WB cycle -> wb_vector_we=1, wb_data equals it; change mem_readdata same cycle -> wb_data follows.
REQ-039 Stall 3 cycles then release -> wb_valid low 3 cycles, high 1 cycle; stall_cnt=3, retired_cnt=1 (macro on).
REQ-040 Scalar write to rd=0 -> wb_valid=1, wb_scalar_we=0; flush and stall together -> bubble, stall_cnt unchanged.
REQ-041 Reset asserted asynchronously mid-stream (between edges) -> wb_valid, write enables, wb_data go 0 immediately; counters 0.
REQ-042 Counter wrap: preload via 2^32-1 retirements (or forced) -> next retirement reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths and write-back source encoding for the CPU pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;
    localparam int VLEN = 128;
    localparam int RA_W = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module  : mem_wb_stage_if
// Brief   : MEM->WB pipeline bundle: MEM-side inputs, WB outputs, perf counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_if #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int VLEN = cpu_pkg::VLEN,
    parameter int RA_W = cpu_pkg::RA_W
);

    logic            stall;
    logic            flush;
    logic            in_valid;
    logic            in_vector;
    logic            in_mem_to_reg;
    logic            in_reg_write;
    logic [RA_W-1:0] in_rd;
    logic [VLEN-1:0] in_alu_result;
    logic [VLEN-1:0] mem_readdata;

    logic            wb_valid;
    logic            wb_scalar_we;
    logic            wb_vector_we;
    logic [RA_W-1:0] wb_rd;
    logic [VLEN-1:0] wb_data;
    logic [31:0]     retired_cnt;
    logic [31:0]     stall_cnt;

    modport master (
        output stall, flush, in_valid, in_vector, in_mem_to_reg, in_reg_write,
               in_rd, in_alu_result, mem_readdata,
        input  wb_valid, wb_scalar_we, wb_vector_we, wb_rd, wb_data,
               retired_cnt, stall_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_vector, in_mem_to_reg, in_reg_write,
               in_rd, in_alu_result, mem_readdata,
        output wb_valid, wb_scalar_we, wb_vector_we, wb_rd, wb_data,
               retired_cnt, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/event_counter.sv
// ============================================================================
// Module  : event_counter
// Brief   : Free-running wrapping event counter with enable and async reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module event_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en,
    output logic      [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module  : mem_wb_stage
// Brief   : MEM/WB pipeline register with combinational load-data bypass.
//           Define MEM_WB_PERF_CNT_EN to build the retire/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int VLEN = cpu_pkg::VLEN,
    parameter int RA_W = cpu_pkg::RA_W
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_wb_stage_if.slave bus
);

    import cpu_pkg::*;

    logic            r_valid;
    logic            r_vector;
    wb_src_t         r_src;
    logic            r_reg_write;
    logic [RA_W-1:0] r_rd;
    logic [VLEN-1:0] r_alu_result;

    logic [VLEN-1:0] w_src_data;
    logic [VLEN-1:0] w_wb_data;

    // Flush and stall both inject a bubble; only a stall is meant to keep
    // the data fields, a flush simply leaves them untouched as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_vector     <= 1'b0;
            r_src        <= WB_ALU;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_alu_result <= '0;
        end else if (bus.flush) begin
            r_valid      <= 1'b0;
        end else if (bus.stall) begin
            r_valid      <= 1'b0;
        end else begin
            r_valid      <= bus.in_valid;
            r_vector     <= bus.in_vector;
            r_src        <= bus.in_mem_to_reg ? WB_MEM : WB_ALU;
            r_reg_write  <= bus.in_reg_write;
            r_rd         <= bus.in_rd;
            r_alu_result <= bus.in_alu_result;
        end
    end

    // Load data arrives during the WB cycle, so it bypasses the register.
    always_comb begin
        w_src_data = (r_src == WB_MEM) ? bus.mem_readdata : r_alu_result;
        w_wb_data  = w_src_data;
        if (!r_vector) begin
            w_wb_data = {{(VLEN-XLEN){1'b0}}, w_src_data[XLEN-1:0]};
        end
    end

    assign bus.wb_valid     = r_valid;
    assign bus.wb_rd        = r_rd;
    assign bus.wb_data      = w_wb_data;
    assign bus.wb_scalar_we = r_valid & r_reg_write & ~r_vector & (r_rd != '0);
    assign bus.wb_vector_we = r_valid & r_reg_write & r_vector;

`ifdef MEM_WB_PERF_CNT_EN
    generate
        if (1'b1) begin : g_perf_cnt
            event_counter #(
                .WIDTH (32)
            ) u_retired_cnt (
                .clk   (clk),
                .reset (reset),
                .en    (r_valid),
                .count (bus.retired_cnt)
            );

            event_counter #(
                .WIDTH (32)
            ) u_stall_cnt (
                .clk   (clk),
                .reset (reset),
                .en    (bus.stall & ~bus.flush),
                .count (bus.stall_cnt)
            );
        end
    endgenerate
`else
    assign bus.retired_cnt = '0;
    assign bus.stall_cnt   = '0;
`endif

endmodule

`default_nettype wire
